// File: rtl/bram_fifo_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl_pkg
// Shared defaults for the BRAM-backed streaming FIFO controller.
//   BRAMWIDE_DEF : default data width (must match the attached BRAM)
//   BRAMDEPW_DEF : default BRAM address width
//   BRAMDEEP_DEF : default BRAM depth (2**BRAMDEPW_DEF)
//   depth_consistent() : true when a depth equals 2**address-width
// ---------------------------------------------------------------------------
package bram_fifo_ctrl_pkg;

    localparam int BRAMWIDE_DEF = 32;
    localparam int BRAMDEPW_DEF = 7;
    localparam int BRAMDEEP_DEF = 128;

    function automatic bit depth_consistent(input int depw, input int deep);
        return deep == (1 << depw);
    endfunction

    localparam bit DEF_DEPTH_OK = depth_consistent(BRAMDEPW_DEF, BRAMDEEP_DEF);

endpackage

// File: rtl/bram_fifo_obuf.sv
// ---------------------------------------------------------------------------
// bram_fifo_obuf
// Two-entry output buffer that absorbs BRAM read data and presents the
// FIFO head word to the consumer.
//   clk       : clock, posedge
//   rst_n     : synchronous active-low reset
//   cap_vld   : BRAM read data is valid this cycle, write it to the tail
//   cap_data  : BRAM read data
//   pop       : head word consumed this cycle (already qualified by out_valid)
//   out_valid : buffer holds at least one word
//   out_data  : head word
//   occ       : number of words held, 0..2
// ---------------------------------------------------------------------------
module bram_fifo_obuf
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = BRAMWIDE_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cap_vld,
    input  logic [WIDTH-1:0] cap_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  head_q, head_d;
    logic                  tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    always_comb begin
        mem_d = mem_q;
        if (cap_vld) begin
            mem_d[tail_q] = cap_data;
        end
        // With only two slots the indices simply toggle on each use.
        tail_d = tail_q ^ cap_vld;
        head_d = head_q ^ pop;
        occ_d  = occ_q + {1'b0, cap_vld} - {1'b0, pop};
    end

    // Data slots are cleared too so the head word reads zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q  <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = mem_q[head_q];
    assign occ       = occ_q;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// bram_fifo_ctrl
// Streaming FIFO controller mastering a simple dual-port BRAM with a
// registered (1-cycle) read port. A 2-entry output buffer hides the read
// latency so the pop side sustains one word per cycle.
//   Clk, Rest              : clock (posedge), synchronous active-low reset
//   InValid/InReady/InData : push interface
//   OutValid/OutReady/OutData : pop interface
//   Count                  : words held (BRAM + in-flight read + buffer)
//   BramREN/BramRADDR      : BRAM read port request
//   BramWEN/BramWADDR/BramDIN : BRAM write port
//   BramDOUT               : BRAM read data, valid the cycle after BramREN
// ---------------------------------------------------------------------------
module bram_fifo_ctrl
    import bram_fifo_ctrl_pkg::*;
#(
    parameter int BRAMWIDE = BRAMWIDE_DEF,
    parameter int BRAMDEPW = BRAMDEPW_DEF,
    parameter int BRAMDEEP = BRAMDEEP_DEF
) (
    input  logic                Clk,
    input  logic                Rest,
    input  logic                InValid,
    output logic                InReady,
    input  logic [BRAMWIDE-1:0] InData,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [BRAMWIDE-1:0] OutData,
    output logic [BRAMDEPW+1:0] Count,
    output logic                BramREN,
    output logic                BramWEN,
    output logic [BRAMDEPW-1:0] BramRADDR,
    output logic [BRAMDEPW-1:0] BramWADDR,
    output logic [BRAMWIDE-1:0] BramDIN,
    input  logic [BRAMWIDE-1:0] BramDOUT
);

    if (!depth_consistent(BRAMDEPW, BRAMDEEP)) begin : g_depth_check
        $error("bram_fifo_ctrl: BRAMDEEP must equal 2**BRAMDEPW");
    end

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    localparam logic [BRAMDEPW:0] PTR_ONE  = {{BRAMDEPW{1'b0}}, 1'b1};
    localparam logic [BRAMDEPW:0] FULL_CNT = {1'b1, {BRAMDEPW{1'b0}}};

    logic [BRAMDEPW:0] wptr_q, wptr_d;
    logic [BRAMDEPW:0] rptr_q, rptr_d;
    logic              inflight_q, inflight_d;
    logic [BRAMDEPW:0] bcnt;
    logic              push, pop, issue;
    logic              out_valid;
    logic [1:0]        occ;

    always_comb begin
        bcnt = wptr_q - rptr_q;
        push = InValid & InReady;
        pop  = out_valid & OutReady;
        // Read only if the word will have a free buffer slot when it lands:
        // occ + inflight - pop < 2, rearranged to avoid unsigned underflow.
        issue = (bcnt != '0) &&
                (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

        wptr_d     = push  ? (wptr_q + PTR_ONE) : wptr_q;
        rptr_d     = issue ? (rptr_q + PTR_ONE) : rptr_q;
        inflight_d = issue;
    end

    always_ff @(posedge Clk) begin
        if (!Rest) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            inflight_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            inflight_q <= inflight_d;
        end
    end

    // A read returning just after reset is dropped because inflight_q is 0.
    bram_fifo_obuf #(
        .WIDTH (BRAMWIDE)
    ) u_obuf (
        .clk       (Clk),
        .rst_n     (Rest),
        .cap_vld   (inflight_q),
        .cap_data  (BramDOUT),
        .pop       (pop),
        .out_valid (out_valid),
        .out_data  (OutData),
        .occ       (occ)
    );

    // InReady looks only at the BRAM fill; the buffer adds two words beyond.
    assign InReady   = (bcnt != FULL_CNT);
    assign OutValid  = out_valid;
    assign BramWEN   = push;
    assign BramWADDR = wptr_q[BRAMDEPW-1:0];
    assign BramDIN   = InData;
    assign BramREN   = issue;
    assign BramRADDR = rptr_q[BRAMDEPW-1:0];
    assign Count     = {1'b0, bcnt}
                     + {{(BRAMDEPW+1){1'b0}}, inflight_q}
                     + {{BRAMDEPW{1'b0}}, occ};

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
module tb_bram_fifo_ctrl;

    localparam int W    = 32;
    localparam int DEPW = 7;
    localparam int DEEP = 128;

    logic            Clk;
    logic            Rest;
    logic            InValid;
    logic            InReady;
    logic [W-1:0]    InData;
    logic            OutValid;
    logic            OutReady;
    logic [W-1:0]    OutData;
    logic [DEPW+1:0] Count;
    logic            BramREN;
    logic            BramWEN;
    logic [DEPW-1:0] BramRADDR;
    logic [DEPW-1:0] BramWADDR;
    logic [W-1:0]    BramDIN;
    logic [W-1:0]    BramDOUT;

    bram_fifo_ctrl #(
        .BRAMWIDE (W),
        .BRAMDEPW (DEPW),
        .BRAMDEEP (DEEP)
    ) dut (
        .Clk       (Clk),
        .Rest      (Rest),
        .InValid   (InValid),
        .InReady   (InReady),
        .InData    (InData),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutData   (OutData),
        .Count     (Count),
        .BramREN   (BramREN),
        .BramWEN   (BramWEN),
        .BramRADDR (BramRADDR),
        .BramWADDR (BramWADDR),
        .BramDIN   (BramDIN),
        .BramDOUT  (BramDOUT)
    );

    // Simple dual-port BRAM with registered read port.
    logic [W-1:0] bram_mem [0:DEEP-1];
    always @(posedge Clk) begin
        if (BramWEN) bram_mem[BramWADDR] <= BramDIN;
        if (BramREN) BramDOUT <= bram_mem[BramRADDR];
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk;
    int n_fail;

    // Reference model: queue of all held words in order, plus word counts
    // for the BRAM, the outstanding read and the output buffer.
    logic [W-1:0] mq[$];
    int nb, nf, no;
    int wcnt, rcnt;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("out_valid", {63'd0, OutValid}, (no > 0) ? 64'd1 : 64'd0);
        if (no > 0) chk("out_data", {32'd0, OutData}, {32'd0, mq[0]});
        chk("count", {55'd0, Count}, 64'(mq.size()));
        chk("in_ready", {63'd0, InReady}, (nb != DEEP) ? 64'd1 : 64'd0);
    endtask

    // Called at a negedge: optionally checks current outputs, drives the
    // inputs for the coming posedge, advances the model, waits one cycle.
    task automatic drive_cycle(input logic iv, input logic [W-1:0] id,
                               input logic ordy, input logic rn, input bit chk_en);
        int pu, po, is;
        if (chk_en) model_check();
        InValid  = iv;
        InData   = id;
        OutReady = ordy;
        Rest     = rn;
        pu = (iv && nb != DEEP) ? 1 : 0;
        po = (ordy && no > 0) ? 1 : 0;
        is = (nb > 0 && (no + nf - po) < 2) ? 1 : 0;
        #1;
        if (chk_en && rn) begin
            chk("bram_wen", {63'd0, BramWEN}, 64'(pu));
            if (pu != 0) begin
                chk("bram_waddr", {57'd0, BramWADDR}, 64'(wcnt % DEEP));
                chk("bram_din", {32'd0, BramDIN}, {32'd0, id});
            end
            chk("bram_ren", {63'd0, BramREN}, 64'(is));
            if (is != 0) chk("bram_raddr", {57'd0, BramRADDR}, 64'(rcnt % DEEP));
        end
        if (!rn) begin
            mq.delete();
            nb = 0; nf = 0; no = 0; wcnt = 0; rcnt = 0;
        end else begin
            if (po != 0) void'(mq.pop_front());
            if (pu != 0) mq.push_back(id);
            no   = no + nf - po;
            nb   = nb + pu - is;
            nf   = is;
            wcnt = wcnt + pu;
            rcnt = rcnt + is;
        end
        @(negedge Clk);
    endtask

    typedef struct {
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         exp_ov;
        logic [W-1:0] exp_od;
        int           exp_cnt;
        logic         exp_ir;
        logic         exp_ren;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_next, popn, maxc, k;
        bit seen;
        n_chk = 0; n_fail = 0;
        nb = 0; nf = 0; no = 0; wcnt = 0; rcnt = 0;
        Rest = 1'b0; InValid = 1'b0; InData = '0; OutReady = 1'b0;

        // Single push latency: push in cycle 0, REN cycle 1, OutValid cycle 3.
        tbl[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0};
        tbl[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h0,         0, 1'b1, 1'b0};

        @(negedge Clk);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("reset_out_data", {32'd0, OutData}, 64'd0);
        chk("reset_wen", {63'd0, BramWEN}, 64'd0);

        for (int i = 0; i < 5; i++) begin
            chk("tbl_out_valid", {63'd0, OutValid}, {63'd0, tbl[i].exp_ov});
            if (tbl[i].exp_ov) chk("tbl_out_data", {32'd0, OutData}, {32'd0, tbl[i].exp_od});
            chk("tbl_count", {55'd0, Count}, 64'(tbl[i].exp_cnt));
            chk("tbl_in_ready", {63'd0, InReady}, {63'd0, tbl[i].exp_ir});
            chk("tbl_ren", {63'd0, BramREN}, {63'd0, tbl[i].exp_ren});
            drive_cycle(tbl[i].iv, tbl[i].id, tbl[i].ordy, 1'b1, 1'b0);
        end

        // Fill to capacity with the consumer stalled, then drain in order.
        for (int i = 0; i < 130; i++) drive_cycle(1'b1, W'(i), 1'b0, 1'b1, 1'b1);
        chk("full_in_ready", {63'd0, InReady}, 64'd0);
        chk("full_count", {55'd0, Count}, 64'd130);
        drive_cycle(1'b1, 32'd999, 1'b0, 1'b1, 1'b1);
        chk("full_push_ignored", {55'd0, Count}, 64'd130);
        exp_next = 0;
        for (int i = 0; i < 400 && exp_next < 130; i++) begin
            if (OutValid) begin
                chk("drain_order", {32'd0, OutData}, 64'(exp_next));
                exp_next++;
            end
            drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        end
        chk("drain_total", 64'(exp_next), 64'd130);

        // Continuous streaming.
        popn = 0; maxc = 0;
        for (int i = 0; i < 1010; i++) begin
            if (int'(Count) > maxc) maxc = int'(Count);
            if (OutValid) begin
                chk("stream_order", {32'd0, OutData}, {32'd0, 32'h1000_0000 + 32'(popn)});
                popn++;
            end
            drive_cycle(i < 1000, 32'h1000_0000 + 32'(i), 1'b1, 1'b1, 1'b1);
        end
        chk("stream_count_le3", (maxc <= 3) ? 64'd1 : 64'd0, 64'd1);
        chk("stream_total", 64'(popn), 64'd1000);

        // Randomized traffic with varying push/pop bias.
        for (int i = 0; i < 20000; i++) begin
            k = i / 5000;
            drive_cycle(($urandom % 4) < 32'(k + 1), $urandom, ($urandom % 4) >= 32'(k % 3), 1'b1, 1'b1);
        end
        for (int i = 0; i < 150; i++) drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        chk("random_drained", {55'd0, Count}, 64'd0);

        // Pointer wrap at a steady occupancy near 100.
        for (int i = 0; i < 100; i++) drive_cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b1, 1'b1);
        for (int i = 100; i < 400; i++) drive_cycle(1'b1, 32'h2000_0000 + 32'(i), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 150; i++) drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);

        // Reset mid-stream with a read in flight and the buffer occupied.
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 32'h3000_0000 + 32'(i), 1'b0, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        drive_cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_out_valid", {63'd0, OutValid}, 64'd0);
        chk("rst_mid_count", {55'd0, Count}, 64'd0);
        chk("rst_mid_in_ready", {63'd0, InReady}, 64'd1);
        drive_cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("rst_mid_stale_ignored", {55'd0, Count}, 64'd0);
        drive_cycle(1'b1, 32'h0000_0042, 1'b0, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (OutValid) begin
                chk("rst_first_pop", {32'd0, OutData}, 64'h42);
                seen = 1'b1;
            end
            drive_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1);
        end
        chk("rst_pop_seen", {63'd0, seen}, 64'd1);
        chk("rst_final_count", {55'd0, Count}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
